// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   state_t    : arbiter sequencer states (IDLE, LAUNCH, BUSY)
//   GO / STOP  : command bytes exchanged with the authentication block
//   BAUD_CLKS  : clocks per UART bit; FRAME_CLKS is one full 10-bit frame
//   wrap_inc   : modulo increment used to advance the round-robin pointer
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    localparam logic [7:0] GO         = 8'h67;
    localparam logic [7:0] STOP       = 8'h73;
    localparam int         BAUD_CLKS  = 2604;
    localparam int         FRAME_CLKS = 10 * BAUD_CLKS;

    // (v + 1) mod n for 0 <= v < n
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if
// Bundles the requester side and the UART_tx side of the arbiter.
//   req / req_data : per-requester request level and byte (byte i at [8i+7:8i])
//   gnt / done     : per-requester one-cycle grant and completion pulses
//   trmt / tx_data : start pulse and byte towards UART_tx
//   tx_done        : UART_tx completion level
//   busy           : frame in flight
//   timeout_err    : sticky abort flag
// modport master : the arbiter itself
// modport slave  : requesters plus UART_tx (environment side)
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req, req_data, tx_done,
        output gnt, done, trmt, tx_data, busy, timeout_err
    );

    modport slave (
        output req, req_data, tx_done,
        input  gnt, done, trmt, tx_data, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index with highest priority this round
//   o_any : at least one request present
//   o_idx : first set request scanning i_ptr, i_ptr+1, ... wrapping
// Rather than rotating, the search is split in two: the lowest request at or
// above i_ptr wins; if there is none, the lowest request overall wins (wrap).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic               o_any,
    output logic [PW-1:0]      o_idx
);

    logic [NUM_REQ-1:0] w_upper;
    logic [PW-1:0]      w_lo_idx;
    logic [PW-1:0]      w_hi_idx;

    // Requests at or above the pointer
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
        assign w_upper[gi] = i_req[gi] & (PW'(gi) >= i_ptr);
    end

    // Descending scan so the lowest set bit is the last assignment
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = PW'(i);
            end
            if (w_upper[i]) begin
                w_hi_idx = PW'(i);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = (|w_upper) ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter/sequencer sharing one UART_tx among NUM_REQ requesters.
// A winner's byte is captured on the grant edge, trmt is pulsed, tx_data is
// held for the whole frame, and the arbiter waits for tx_done before the next
// arbitration round.
//   clk, rst : clock, synchronous active-high reset (shared with UART_tx)
//   bus      : uart_tx_arb_if.master (req, req_data, tx_done in;
//              gnt, done, trmt, tx_data, busy, timeout_err out)
// Parameters: NUM_REQ (2..8), TIMEOUT_CYC (BUSY cycle limit).
// Optional feature macro UART_TX_ARB_TIMEOUT_EN: when defined, a frame that
// sees no tx_done within TIMEOUT_CYC BUSY cycles is aborted without a done
// pulse and timeout_err is set until reset. When undefined, BUSY waits
// indefinitely and timeout_err is tied low.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 32768
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arb_if.master     bus
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
        $error("uart_tx_arb: parameter out of range");
    end

    state_t             r_state, w_state_next;
    logic [PW-1:0]      r_ptr, w_ptr_next;
    logic [PW-1:0]      r_win, w_win_next;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
    logic [NUM_REQ-1:0] r_done, w_done_next;
    logic               r_trmt, w_trmt_next;
    logic [7:0]         r_tx_data, w_tx_data_next;

    logic               w_any;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_ptr_after;
    logic [7:0]         w_bytes [NUM_REQ];

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0]        r_cnt, w_cnt_next;
    logic               r_timeout_err, w_timeout_err_next;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = bus.req_data[8*gi +: 8];
    end

    // Priority moves to the requester after the one just served
    assign w_ptr_after = PW'(wrap_inc(int'(r_win), NUM_REQ));

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_win_next     = r_win;
        w_tx_data_next = r_tx_data;
        w_gnt_next     = '0;
        w_done_next    = '0;
        w_trmt_next    = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_cnt_next         = r_cnt;
        w_timeout_err_next = r_timeout_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_next     = NUM_REQ'(1) << w_idx;
                    w_trmt_next    = 1'b1;
                    w_tx_data_next = w_bytes[w_idx];
                    w_win_next     = w_idx;
                    w_state_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                // tx_done may still be high from the previous frame here;
                // UART_tx only clears it on the trmt edge, so it is ignored.
                w_state_next = BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                w_cnt_next   = '0;
`endif
            end
            BUSY: begin
                if (bus.tx_done) begin
                    w_done_next  = NUM_REQ'(1) << r_win;
                    w_ptr_next   = w_ptr_after;
                    w_state_next = IDLE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // r_cnt counts completed BUSY cycles, so the abort falls on
                // the edge closing BUSY cycle number TIMEOUT_CYC.
                else if (r_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    w_ptr_next         = w_ptr_after;
                    w_state_next       = IDLE;
                    w_timeout_err_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_win     <= w_win_next;
            r_gnt     <= w_gnt_next;
            r_done    <= w_done_next;
            r_trmt    <= w_trmt_next;
            r_tx_data <= w_tx_data_next;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.trmt    = r_trmt;
    assign bus.tx_data = r_tx_data;
    assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Directed bench for uart_tx_arb with a small UART_tx stand-in that raises
// tx_done a programmable number of cycles after trmt and holds it until the
// next trmt. A transaction-level model (modulo scan for the winner, an
// in-flight flag, a busy-cycle count) predicts every output every cycle.
module tb_uart_tx_arb;

    localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO    = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 32768;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NUM_REQ(N)) bus ();

    uart_tx_arb #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- UART_tx stand-in ----------------
    int frame_len = 24;
    bit stuck     = 1'b0;
    int u_cnt     = 0;

    always @(posedge clk) begin
        if (rst) begin
            u_cnt       <= 0;
            bus.tx_done <= 1'b0;
        end else if (bus.trmt) begin
            bus.tx_done <= 1'b0;
            u_cnt       <= frame_len;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1 && !stuck) begin
                bus.tx_done <= 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    logic [N-1:0] e_gnt  = '0;
    logic [N-1:0] e_done = '0;
    logic         e_trmt = 1'b0;
    logic [7:0]   e_txd  = 8'h00;
    logic         e_terr = 1'b0;
    int           m_ptr  = 0;
    int           m_win  = 0;
    int           m_wait = 0;
    bit           m_infl = 1'b0;
    bit           m_fresh = 1'b0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        e_gnt  <= '0;
        e_done <= '0;
        e_trmt <= 1'b0;
        if (rst) begin
            m_valid <= 1'b1;
            m_ptr   <= 0;
            m_infl  <= 1'b0;
            m_fresh <= 1'b0;
            e_txd   <= 8'h00;
            e_terr  <= 1'b0;
        end else if (!m_infl) begin
            if (bus.req != '0) begin
                e_gnt   <= N'(1) << rr_winner(bus.req, m_ptr);
                e_trmt  <= 1'b1;
                e_txd   <= bus.req_data[8*rr_winner(bus.req, m_ptr) +: 8];
                m_win   <= rr_winner(bus.req, m_ptr);
                m_infl  <= 1'b1;
                m_fresh <= 1'b1;
            end
        end else if (m_fresh) begin
            m_fresh <= 1'b0;
            m_wait  <= 0;
        end else if (bus.tx_done) begin
            e_done <= N'(1) << m_win;
            m_ptr  <= (m_win + 1) % N;
            m_infl <= 1'b0;
        end else if (TO_EN && (m_wait + 1 == TO)) begin
            m_ptr  <= (m_win + 1) % N;
            m_infl <= 1'b0;
            e_terr <= 1'b1;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    // ---------------- compare + event log ----------------
    int         g_log[$];
    logic [7:0] t_log[$];
    int         d_log[$];
    int         d_count    = 0;
    int         txd_glitch = 0;
    logic [7:0] prev_txd   = 8'h00;

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",         bus.gnt,         e_gnt);
            check("done",        bus.done,        e_done);
            check("trmt",        bus.trmt,        e_trmt);
            check("tx_data",     bus.tx_data,     e_txd);
            check("busy",        bus.busy,        m_infl);
            check("timeout_err", bus.timeout_err, e_terr);
            if (bus.gnt != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.gnt[i]) g_log.push_back(i);
                end
                t_log.push_back(bus.tx_data);
            end
            if (bus.done != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.done[i]) d_log.push_back(i);
                end
                d_count <= d_count + 1;
            end
            if (bus.tx_data != prev_txd && bus.gnt == '0 && !rst) begin
                txd_glitch <= txd_glitch + 1;
            end
            prev_txd <= bus.tx_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Run until d_count reaches target; optionally drop each request once granted
    task automatic run_dones(input int target, input int budget, input bit drop);
        int c;
        c = 0;
        while (d_count < target && c < budget) begin
            step();
            if (drop) bus.req = bus.req & ~bus.gnt;
            c++;
        end
        if (d_count < target) check("wait_done", d_count, target);
    endtask

    task automatic run_gnts(input int target, input int budget);
        int c;
        c = 0;
        while (g_log.size() < target && c < budget) begin
            step();
            bus.req = bus.req & ~bus.gnt;
            c++;
        end
        if (g_log.size() < target) check("wait_gnt", g_log.size(), target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int bc;
        bus.req      = '0;
        bus.req_data = '0;
        step();
        step();
        step();
        $display("reset: checking idle outputs");
        check("rst_gnt",  bus.gnt,     4'h0);
        check("rst_done", bus.done,    4'h0);
        check("rst_trmt", bus.trmt,    1'b0);
        check("rst_busy", bus.busy,    1'b0);
        check("rst_txd",  bus.tx_data, 8'h00);
        check("rst_terr", bus.timeout_err, 1'b0);
        rst = 1'b0;
        step();

        // T1: single requester, full-length frame
        frame_len = uart_tx_arb_pkg::FRAME_CLKS;
        bus.req_data[15:8] = uart_tx_arb_pkg::GO;
        bus.req = 4'b0010;
        step();
        check("t1_gnt",  bus.gnt,     4'b0010);
        check("t1_trmt", bus.trmt,    1'b1);
        check("t1_txd",  bus.tx_data, 8'h67);
        bus.req = '0;
        run_dones(1, 27000, 1'b1);
        check("t1_done_idx", (d_log.size() > 0) ? d_log[0] : -1, 1);
        $display("txn T1: gnt=1 data=67 done count=%0d", d_count);

        // T2: simultaneous 0 and 2 from ptr=0
        do_reset();
        frame_len = 24;
        g_log.delete(); t_log.delete(); d_log.delete();
        base = d_count;
        bus.req_data = {8'h00, uart_tx_arb_pkg::STOP, 8'h00, uart_tx_arb_pkg::GO};
        bus.req = 4'b0101;
        run_dones(base + 2, 200, 1'b1);
        check("t2_order0", (g_log.size() > 0) ? g_log[0] : -1, 0);
        check("t2_order1", (g_log.size() > 1) ? g_log[1] : -1, 2);
        check("t2_data0",  (t_log.size() > 0) ? t_log[0] : 8'hxx, 8'h67);
        check("t2_data1",  (t_log.size() > 1) ? t_log[1] : 8'hxx, 8'h73);
        check("t2_dones",  d_count - base, 2);
        $display("txn T2: grants=%0d dones=%0d", g_log.size(), d_count - base);

        // ptr is now 3: requester 3 beats requester 0
        bus.req_data = {8'h33, 8'h00, 8'h00, 8'h67};
        bus.req = 4'b1001;
        run_gnts(3, 20);
        bus.req = '0;
        run_dones(base + 3, 200, 1'b1);
        check("t2_ptr3", (g_log.size() > 2) ? g_log[2] : -1, 3);
        check("t2_data3", (t_log.size() > 2) ? t_log[2] : 8'hxx, 8'h33);
        $display("txn ptr3: winner=%0d", (g_log.size() > 2) ? g_log[2] : -1);

        // T3: all four held for 8 frames
        do_reset();
        g_log.delete(); t_log.delete(); d_log.delete();
        base = d_count;
        txd_glitch = 0;
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req = 4'b1111;
        run_dones(base + 8, 600, 1'b0);
        bus.req = '0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            check("t3_order", (g_log.size() > i) ? g_log[i] : -1, i % 4);
        end
        check("t3_count", g_log.size(), 8);
        check("t3_glitch", txd_glitch, 0);
        $display("txn T3: grants=%0d glitches=%0d", g_log.size(), txd_glitch);

        // T4: req[3] pulsed for one cycle while serving 0
        g_log.delete();
        base = d_count;
        bus.req = 4'b0001;
        run_gnts(1, 10);
        repeat (5) step();
        bus.req = 4'b1000;
        step();
        bus.req = '0;
        run_dones(base + 1, 200, 1'b1);
        repeat (10) step();
        check("t4_grants", g_log.size(), 1);
        check("t4_busy", bus.busy, 1'b0);
        $display("txn T4: grants=%0d", g_log.size());

        // T5: reset 5000 cycles into a frame
        frame_len = 6000;
        g_log.delete();
        base = d_count;
        bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req = 4'b0100;
        run_gnts(1, 10);
        repeat (5000) step();
        check("t5_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        check("t5_gnt",  bus.gnt,     4'h0);
        check("t5_done", bus.done,    4'h0);
        check("t5_trmt", bus.trmt,    1'b0);
        check("t5_busy", bus.busy,    1'b0);
        check("t5_txd",  bus.tx_data, 8'h00);
        rst = 1'b0;
        repeat (1200) step();
        check("t5_no_done", d_count - base, 0);
        frame_len = 24;
        bus.req_data = {8'h00, 8'h00, 8'h22, 8'h21};
        bus.req = 4'b0011;
        run_dones(base + 1, 200, 1'b1);
        check("t5_ptr0", (g_log.size() > 1) ? g_log[1] : -1, 0);
        $display("txn T5: post-reset winner=%0d", (g_log.size() > 1) ? g_log[1] : -1);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // T6: tx_done never arrives
        stuck = 1'b1;
        base  = d_count;
        g_log.delete();
        bus.req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        bus.req = 4'b0010;
        run_gnts(1, 10);
        bc = 1;
        while (bus.busy && bc < 300) begin
            step();
            if (bus.busy) bc++;
        end
        check("t6_busy_cycles", bc, TO + 1);
        check("t6_terr", bus.timeout_err, 1'b1);
        check("t6_no_done", d_count - base, 0);
        stuck = 1'b0;
        bus.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        bus.req = 4'b0100;
        run_dones(base + 1, 200, 1'b1);
        check("t6_next_gnt", (g_log.size() > 1) ? g_log[1] : -1, 2);
        check("t6_terr_sticky", bus.timeout_err, 1'b1);
        $display("txn T6: busy_cycles=%0d", bc);
`else
        bc = 0;
        check("no_timeout_err", bus.timeout_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares the single UART_tx transmitter among NUM_REQ requesters (telemetry, command ack, debug).
- Captures the winning requester's byte, pulses trmt, holds tx_data stable for the whole frame, and waits for tx_done.
- Reports per-requester grant and completion.
- Sits between the control/auth logic and UART_tx in the Segway top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 32768, max cycles in BUSY before abort. One frame is 10 bits × 2604 clks = 26040.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester transmit request (level)
- req_data  in  NUM_REQ*8  byte for requester i at bits [8i+7:8i]
- gnt  out  NUM_REQ  one-cycle pulse: byte of requester i captured
- done  out  NUM_REQ  one-cycle pulse: requester i's frame finished
- trmt  out  1  one-cycle start pulse to UART_tx
- tx_data  out  8  byte to UART_tx; stable from trmt until next grant
- tx_done  in  1  UART_tx completion level; cleared by UART_tx on trmt
- busy  out  1  high in LAUNCH or BUSY
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset: state=IDLE, ptr=0. gnt, done, trmt, busy, timeout_err all 0. tx_data=8'h00. Reset mid-frame abandons the frame with no done; UART_tx shares rst.
- States: IDLE, LAUNCH, BUSY.
- IDLE, req!=0 in cycle N:
  - Winner = first set req bit scanning ptr, ptr+1, … mod NUM_REQ.
  - Next edge (cycle N+1): tx_data<=req_data[winner], gnt[winner]=1, trmt=1, state=LAUNCH, win_idx latched.
- LAUNCH: lasts exactly one cycle. tx_done is ignored (it may still be stale-high). Go to BUSY.
- BUSY: wait for tx_done==1. On the edge after tx_done is seen:
  - done[win_idx]=1 for one cycle
  - ptr<=(win_idx+1) mod NUM_REQ
  - state=IDLE
- Back-to-back: a new grant may occur the cycle after done (IDLE lasts ≥1 cycle). A requester holding req continuously re-arbitrates normally. It has no priority over others.
- req_data is sampled only on the grant edge. A req dropped before the grant is not served.
- gnt and done are mutually exclusive in time. Only one requester is ever in flight.
- busy=1 in LAUNCH and BUSY, 0 in IDLE.
- tx_data never changes outside the grant edge.
- Priority wraps: ptr=NUM_REQ-1 with winner NUM_REQ-1 sets ptr to 0.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on LAUNCH and increments each BUSY cycle.
  - Reaching TIMEOUT_CYC with no tx_done: state=IDLE, ptr advances past win_idx, no done pulse, timeout_err<=1.
  - timeout_err stays 1 until rst.
  - tx_done arriving in the same cycle as the limit counts as success.
- Undefined: no counter. BUSY waits indefinitely. timeout_err is tied to 0 (port kept).

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state enum (IDLE, LAUNCH, BUSY)
  - command localparams GO=8'h67, STOP=8'h73
  - BAUD_CLKS=2604
- Sub-module rr_pick: combinational round-robin picker. Inputs req, ptr. Outputs any, idx.

Test Plan:
- Single requester: req[1]=1, req_data=8'h67 → gnt[1] and trmt at cycle N+1, tx_data=8'h67. Auth_blk loopback reaches PWR1. done[1] after ~26040 clks. ptr=2.
- Simultaneous req[0], req[2] at ptr=0: grant order 0 then 2. tx_data 8'h67 then 8'h73. Two done pulses. ptr=3.
- All four requesters hold req for 8 frames: grant order 0,1,2,3,0,1,2,3. tx_data never changes mid-frame.
- req[3] pulsed for one cycle while BUSY serving 0: no gnt[3], next IDLE idles.
- rst asserted 5000 clks into a frame: all outputs 0 next cycle, ptr=0. No done ever issued for the abandoned frame.
- Timeout build, TIMEOUT_CYC=100, tx_done forced 0:
  - abort at cycle 100 of BUSY, timeout_err=1, no done.
  - The next requester is still granted afterward.
